quad_edge_emitter: RTL

QUAD_EDGE_EMITTER -- requirements
Module: quad_edge_emitter

---
 rtl/quad_edge_emitter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/quad_edge_emitter.sv
// Quad edge emitter.
// Buffers screen-space quads from the geometry stage in a small FIFO. Each
// quad is emitted as four edges, vertex k to vertex (k+1) mod 4, on a
// registered valid/ready output.
//
// Output handshake: an edge transfers on a rising edge where edge_valid and
// edge_ready are both 1. While edge_valid=1 and edge_ready=0, every edge_*
// output holds. edge_valid never waits on edge_ready, and edge_ready is
// ignored while edge_valid=0.
module quad_edge_emitter #(
   parameter int DEPTH = 4,
   parameter int XW    = 10
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [3:0][1:0][XW-1:0]      ssVertices,
   input  logic [15:0]                  tuser_in,
   output logic                         edge_valid,
   input  logic                         edge_ready,
   output logic [XW-1:0]                edge_x0,
   output logic [XW-1:0]                edge_y0,
   output logic [XW-1:0]                edge_x1,
   output logic [XW-1:0]                edge_y1,
   output logic [14:0]                  edge_id,
   output logic [1:0]                   edge_idx,
   output logic                         edge_last,
   output logic                         edge_horiz,
   output logic [$clog2(DEPTH):0]       fifo_count,
   output logic                         overflow,
   output logic                         fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef logic [3:0][1:0][XW-1:0] quad_t;
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t      state, state_n;
   quad_t       mem_v  [DEPTH];
   logic [14:0] mem_id [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;

   logic hs, pop, full, wr_req, wr_en, ovf_set, remain;
   quad_t       nxt_v, load_v;
   logic [14:0] nxt_id, load_id;
   logic        load;
   logic [1:0]  load_k, end_k;
   logic [XW-1:0] e_x0, e_y0, e_x1, e_y1;

   assign fsm_state = (state == EMIT);

   // FIFO control: a pop frees a slot in the same cycle, so full+write+pop
   // is accepted; a write into a full FIFO without a pop is dropped.
   always_comb begin
      hs         = edge_valid & edge_ready;
      pop        = hs & (edge_idx == 2'd3);
      full       = (fifo_count == CW'(DEPTH));
      wr_req     = tuser_in[15];
      wr_en      = wr_req & (~full | pop);
      ovf_set    = wr_req & full & ~pop;
      rd_ptr_nxt = rd_ptr + AW'(1);
      // After a pop with a single entry left, the only next quad is the one
      // being written right now, so it is forwarded straight from the input.
      if (fifo_count == CW'(1)) begin
         nxt_v  = ssVertices;
         nxt_id = tuser_in[14:0];
      end else begin
         nxt_v  = mem_v[rd_ptr_nxt];
         nxt_id = mem_id[rd_ptr_nxt];
      end
      remain = (fifo_count > CW'(1)) | wr_en;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr_nxt;
         fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
         if (ovf_set) overflow <= 1'b1;
      end
   end

   // FIFO storage; contents are don't-care while the count says empty.
   always_ff @(posedge Clk) begin
      if (!Reset && wr_en) begin
         mem_v[wr_ptr]  <= ssVertices;
         mem_id[wr_ptr] <= tuser_in[14:0];
      end
   end

   // Next state and which edge (if any) to load into the output registers.
   always_comb begin
      state_n = state;
      load    = 1'b0;
      load_k  = 2'd0;
      load_v  = mem_v[rd_ptr];
      load_id = mem_id[rd_ptr];
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               state_n = EMIT;
               load    = 1'b1;
            end
         end
         EMIT: begin
            if (hs) begin
               if (edge_idx != 2'd3) begin
                  load   = 1'b1;
                  load_k = edge_idx + 2'd1;
               end else if (remain) begin
                  load    = 1'b1;
                  load_v  = nxt_v;
                  load_id = nxt_id;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Endpoint selection for the edge being loaded; the 2-bit add wraps 3->0.
   always_comb begin
      end_k = load_k + 2'd1;
      e_x0  = load_v[load_k][0];
      e_y0  = load_v[load_k][1];
      e_x1  = load_v[end_k][0];
      e_y1  = load_v[end_k][1];
   end

   // State register and registered edge outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         edge_valid <= 1'b0;
         edge_idx   <= 2'd0;
         edge_id    <= '0;
         edge_x0    <= '0;
         edge_y0    <= '0;
         edge_x1    <= '0;
         edge_y1    <= '0;
         edge_horiz <= 1'b0;
         edge_last  <= 1'b0;
      end else begin
         state      <= state_n;
         edge_valid <= (state_n == EMIT);
         if (load) begin
            edge_idx   <= load_k;
            edge_id    <= load_id;
            edge_x0    <= e_x0;
            edge_y0    <= e_y0;
            edge_x1    <= e_x1;
            edge_y1    <= e_y1;
            edge_horiz <= (e_y0 == e_y1);
            edge_last  <= (load_k == 2'd3);
         end
      end
   end

endmodule
